// File: rtl/fpu_arbiter_pkg.sv
// Shared types and opcode constants for the two-requester FPU arbiter.
package defs;
    localparam int FPU_OP_W    = 8;
    localparam int FPU_FPCSR_W = 12;

    // pfpu32 opcode map: bit 3 selects the compare unit
    localparam logic [FPU_OP_W-1:0] FPU_ADD  = 8'h00;
    localparam logic [FPU_OP_W-1:0] FPU_SUB  = 8'h01;
    localparam logic [FPU_OP_W-1:0] FPU_MUL  = 8'h02;
    localparam logic [FPU_OP_W-1:0] FPU_DIV  = 8'h03;
    localparam logic [FPU_OP_W-1:0] FPU_ITOF = 8'h04;
    localparam logic [FPU_OP_W-1:0] FPU_FTOI = 8'h05;
    localparam logic [FPU_OP_W-1:0] FPU_SFEQ = 8'h08;
    localparam logic [FPU_OP_W-1:0] FPU_SFNE = 8'h09;
    localparam logic [FPU_OP_W-1:0] FPU_SFGT = 8'h0A;
    localparam logic [FPU_OP_W-1:0] FPU_SFGE = 8'h0B;
    localparam logic [FPU_OP_W-1:0] FPU_SFLT = 8'h0C;
    localparam logic [FPU_OP_W-1:0] FPU_SFLE = 8'h0D;

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} fpu_arb_state_t;

    typedef struct packed {
        logic [FPU_OP_W-1:0] op;
        logic [31:0]         a;
        logic [31:0]         b;
        logic [1:0]          rm;
    } fpu_req_t;

    typedef struct packed {
        logic [31:0]            result;
        logic                   cmp;
        logic                   is_cmp;
        logic [FPU_FPCSR_W-1:0] fpcsr;
        logic                   err;
    } fpu_resp_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester issue/response channels plus the FPU pin bundle seen by the arbiter.
interface fpu_arbiter_if #(
    parameter int OP_W    = 8,
    parameter int FPCSR_W = 12
) ();
    logic                      flush_i;
    logic [1:0]                req_valid_i;
    logic [1:0]                req_ready_o;
    logic [1:0][OP_W-1:0]      req_op_i;
    logic [1:0][31:0]          req_a_i;
    logic [1:0][31:0]          req_b_i;
    logic [1:0][1:0]           req_rm_i;
    logic [1:0]                resp_valid_o;
    logic [31:0]               resp_result_o;
    logic                      resp_cmp_o;
    logic                      resp_is_cmp_o;
    logic [FPCSR_W-1:0]        resp_fpcsr_o;
    logic                      resp_err_o;
    logic                      fpu_decode_o;
    logic                      fpu_execute_o;
    logic                      fpu_flush_o;
    logic [OP_W-1:0]           fpu_op_o;
    logic [31:0]               fpu_a_o;
    logic [31:0]               fpu_b_o;
    logic [1:0]                fpu_rm_o;
    logic [31:0]               fpu_result_i;
    logic                      fpu_arith_valid_i;
    logic                      fpu_cmp_flag_i;
    logic                      fpu_cmp_valid_i;
    logic [FPCSR_W-1:0]        fpu_fpcsr_i;

    modport slave (
        input  flush_i, req_valid_i, req_op_i, req_a_i, req_b_i, req_rm_i,
               fpu_result_i, fpu_arith_valid_i, fpu_cmp_flag_i, fpu_cmp_valid_i, fpu_fpcsr_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_cmp_o, resp_is_cmp_o,
               resp_fpcsr_o, resp_err_o, fpu_decode_o, fpu_execute_o, fpu_flush_o,
               fpu_op_o, fpu_a_o, fpu_b_o, fpu_rm_o
    );

    modport master (
        output flush_i, req_valid_i, req_op_i, req_a_i, req_b_i, req_rm_i,
               fpu_result_i, fpu_arith_valid_i, fpu_cmp_flag_i, fpu_cmp_valid_i, fpu_fpcsr_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_cmp_o, resp_is_cmp_o,
               resp_fpcsr_o, resp_err_o, fpu_decode_o, fpu_execute_o, fpu_flush_o,
               fpu_op_o, fpu_a_o, fpu_b_o, fpu_rm_o
    );
endinterface

// File: rtl/fpu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer only moves on an accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_idx,
    output logic       gnt_vld
);
    logic last;

    // On a tie the requester not served last wins; otherwise the sole requester.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = (req == 2'b11) ? ~last : req[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    last <= 1'b1;
        else if (accept) last <= gnt_idx;
    end
endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU between two requesters: accept, decode, execute with timeout, respond.
module fpu_arbiter
    import defs::*;
#(
    parameter int TIMEOUT = 64,
    parameter int OP_W    = FPU_OP_W,
    parameter int FPCSR_W = FPU_FPCSR_W
) (
    input logic          clk,
    input logic          reset_n,
    fpu_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    fpu_arb_state_t state;
    logic [TW-1:0]  timer;
    logic           owner;
    fpu_req_t       opr;
    fpu_resp_t      rsp;
    logic           decode_q, execute_q;
    logic [1:0]     resp_vld_q;
    logic           gnt_idx, gnt_vld, accept, fpu_vld, timeout_hit;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid_i),
        .accept  (accept),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // reset_n gating keeps ready low while reset is held, even with requests pending
    assign accept      = reset_n & (state == IDLE) & gnt_vld & ~bus.flush_i;
    assign fpu_vld     = bus.fpu_arith_valid_i | bus.fpu_cmp_valid_i;
    // timer holds completed EXEC cycles, so this is the TIMEOUT-th EXEC cycle
    assign timeout_hit = (state == EXEC) & ~fpu_vld & (timer == TW'(TIMEOUT - 1));

    assign bus.req_ready_o   = accept ? onehot2(gnt_idx) : 2'b00;
    assign bus.resp_valid_o  = resp_vld_q;
    assign bus.resp_result_o = rsp.result;
    assign bus.resp_cmp_o    = rsp.cmp;
    assign bus.resp_is_cmp_o = rsp.is_cmp;
    assign bus.resp_fpcsr_o  = FPCSR_W'(rsp.fpcsr);
    assign bus.resp_err_o    = rsp.err;
    assign bus.fpu_decode_o  = decode_q;
    assign bus.fpu_execute_o = execute_q;
    assign bus.fpu_flush_o   = bus.flush_i | timeout_hit;
    assign bus.fpu_op_o      = OP_W'(opr.op);
    assign bus.fpu_a_o       = opr.a;
    assign bus.fpu_b_o       = opr.b;
    assign bus.fpu_rm_o      = opr.rm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            owner      <= 1'b0;
            opr        <= '0;
            rsp        <= '0;
            decode_q   <= 1'b0;
            execute_q  <= 1'b0;
            resp_vld_q <= 2'b00;
        end else begin
            decode_q   <= 1'b0;
            resp_vld_q <= 2'b00;
            case (state)
                IDLE: if (accept) begin
                    opr <= '{op: FPU_OP_W'(bus.req_op_i[gnt_idx]), a: bus.req_a_i[gnt_idx],
                             b: bus.req_b_i[gnt_idx], rm: bus.req_rm_i[gnt_idx]};
                    owner    <= gnt_idx;
                    decode_q <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    timer <= '0;
                    if (bus.flush_i) begin
                        opr   <= '0;
                        state <= IDLE;
                    end else begin
                        execute_q <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.flush_i) begin
                        execute_q <= 1'b0;
                        opr       <= '0;
                        state     <= IDLE;
                    end else if (fpu_vld) begin
                        rsp <= '{result: bus.fpu_result_i, cmp: bus.fpu_cmp_flag_i,
                                 is_cmp: bus.fpu_cmp_valid_i,
                                 fpcsr: FPU_FPCSR_W'(bus.fpu_fpcsr_i), err: 1'b0};
                        resp_vld_q <= onehot2(owner);
                        execute_q  <= 1'b0;
                        state      <= RESP;
                    end else if (timeout_hit) begin
                        rsp        <= '{result: '0, cmp: 1'b0, is_cmp: 1'b0, fpcsr: '0, err: 1'b1};
                        resp_vld_q <= onehot2(owner);
                        execute_q  <= 1'b0;
                        state      <= RESP;
                    end else if (timer != TW'(TIMEOUT)) begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    opr   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
